// File: rtl/host_cycle_ctrl_if.sv
// CPU-side request interface for host_cycle_ctrl.
// Handshake: the requester raises cpu_req with cpu_rnw, cpu_data and the
// dec_* flags stable. The sequencer captures them once on acceptance and
// answers with a one-clk cpu_ack. busy is high from acceptance until
// cpu_ack. The requester drops cpu_req in the cpu_ack cycle. If cpu_req is
// still high one clk later, that is taken as a new access.
interface host_cycle_ctrl_if;
  logic       cpu_req;
  logic       cpu_rnw;
  logic [7:0] cpu_data;
  logic       dec_fe4x;
  logic       dec_rom_reg;
  logic       dec_shadow_reg;
  logic       cpu_ack;
  logic       busy;

  modport master (
    output cpu_req, cpu_rnw, cpu_data, dec_fe4x, dec_rom_reg, dec_shadow_reg,
    input  cpu_ack, busy
  );

  modport slave (
    input  cpu_req, cpu_rnw, cpu_data, dec_fe4x, dec_rom_reg, dec_shadow_reg,
    output cpu_ack, busy
  );
endinterface

// File: rtl/host_cycle_ctrl.sv
// host_cycle_ctrl: sequences CPU accesses onto the host bus, aligned to bbc_phi0.
// Optional feature macro: HOST_1MHZ_STRETCH_EN. When it is defined, FE4x
// accesses are stretched to two phi0 periods on the 1 MHz phase.
// state_dbg exposes the FSM state: 0 idle, 1 wait_edge, 2 addr, 3 data, 4 end.
module host_cycle_ctrl (
  input  logic             clk,
  input  logic             resetb,
  input  logic             bbc_phi0,
  host_cycle_ctrl_if.slave cpu,
  output logic             lat_en,
  output logic             bbc_rnw,
  output logic [3:0]       rom_bank,
  output logic             shadow_en,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_EDGE = 3'd1,
    S_ADDR      = 3'd2,
    S_DATA      = 3'd3,
    S_END       = 3'd4
  } state_t;

  state_t     state, next_state;
  logic       phi0_s1, phi0_s2, phi0_d;
  logic       phi0_rise, phi0_fall;
  logic       req_rnw, req_fe4x, req_rom, req_shadow;
  logic [7:0] req_data;
  logic       stretch_done;
  logic       stretched;
  logic       edge_ok;

  assign phi0_rise = phi0_s2 & ~phi0_d;
  assign phi0_fall = ~phi0_s2 & phi0_d;
  assign state_dbg = state;

  // Bring bbc_phi0 into the clk domain and keep one extra stage for edge detect.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      phi0_s1 <= 1'b0;
      phi0_s2 <= 1'b0;
      phi0_d  <= 1'b0;
    end else begin
      phi0_s1 <= bbc_phi0;
      phi0_s2 <= phi0_s1;
      phi0_d  <= phi0_s2;
    end
  end

`ifdef HOST_1MHZ_STRETCH_EN
  logic ph1m;

  // ph1m marks the 1 MHz phase. A stretched access starts on a fall where it
  // is 1, so the rise that follows clears it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) ph1m <= 1'b0;
    else if (phi0_rise) ph1m <= ~ph1m;
  end

  assign stretched = req_fe4x;
  assign edge_ok   = phi0_fall & (~stretched | ph1m);
`else
  logic unused_fe4x;
  assign unused_fe4x = req_fe4x;
  assign stretched   = 1'b0;
  assign edge_ok     = phi0_fall;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else state <= next_state;
  end

  // Next-state and output decode.
  always_comb begin
    next_state  = state;
    lat_en      = 1'b0;
    bbc_rnw     = 1'b1;
    cpu.cpu_ack = 1'b0;
    cpu.busy    = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (cpu.cpu_req) next_state = S_WAIT_EDGE;
      end
      S_WAIT_EDGE: begin
        if (edge_ok) next_state = S_ADDR;
      end
      S_ADDR: begin
        lat_en  = 1'b1;
        bbc_rnw = req_rnw;
        if (phi0_rise) next_state = S_DATA;
      end
      S_DATA: begin
        lat_en  = 1'b1;
        bbc_rnw = req_rnw;
        if (phi0_fall) begin
          if (stretched && !stretch_done) next_state = S_ADDR;
          else next_state = S_END;
        end
      end
      S_END: begin
        bbc_rnw     = req_rnw;
        cpu.cpu_ack = 1'b1;
        next_state  = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Capture the request on acceptance. Later changes on the CPU side are
  // ignored until the next access is accepted.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      req_rnw    <= 1'b1;
      req_data   <= 8'h00;
      req_fe4x   <= 1'b0;
      req_rom    <= 1'b0;
      req_shadow <= 1'b0;
    end else if (state == S_IDLE && cpu.cpu_req) begin
      req_rnw    <= cpu.cpu_rnw;
      req_data   <= cpu.cpu_data;
      req_fe4x   <= cpu.dec_fe4x;
      req_rom    <= cpu.dec_rom_reg;
      req_shadow <= cpu.dec_shadow_reg;
    end
  end

  // Track whether the first period of a stretched access has been run.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) stretch_done <= 1'b0;
    else if (state == S_IDLE) stretch_done <= 1'b0;
    else if (state == S_DATA && next_state == S_ADDR) stretch_done <= 1'b1;
  end

  // Mirror select-register writes. The update is made on the edge into END,
  // so the new value is already visible while cpu_ack is high.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rom_bank  <= 4'h0;
      shadow_en <= 1'b0;
    end else if (state == S_DATA && next_state == S_END && !req_rnw) begin
      if (req_rom)    rom_bank  <= req_data[3:0];
      if (req_shadow) shadow_en <= req_data[7];
    end
  end

endmodule

// File: tb/tb_host_cycle_ctrl.sv
// Bench for host_cycle_ctrl: clk is about 32 MHz (32 ns) and phi0 is 16 clk per period.
`timescale 1ns/1ps
module tb_host_cycle_ctrl;

  logic       clk;
  logic       resetb;
  logic       bbc_phi0;
  logic       lat_en;
  logic       bbc_rnw;
  logic [3:0] rom_bank;
  logic       shadow_en;
  logic [2:0] state_dbg;
  logic       tb_ph1m;

  int checks;
  int failures;

`ifdef HOST_1MHZ_STRETCH_EN
  localparam int EXP_FE4X_LAT = 32;
`else
  localparam int EXP_FE4X_LAT = 16;
`endif

  host_cycle_ctrl_if cif ();

  host_cycle_ctrl dut (
    .clk       (clk),
    .resetb    (resetb),
    .bbc_phi0  (bbc_phi0),
    .cpu       (cif),
    .lat_en    (lat_en),
    .bbc_rnw   (bbc_rnw),
    .rom_bank  (rom_bank),
    .shadow_en (shadow_en),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #16 clk = ~clk;

  initial begin
    bbc_phi0 = 1'b0;
    #7;
    forever #256 bbc_phi0 = ~bbc_phi0;
  end

  // Reference 1 MHz phase: toggles on each raw phi0 rise after reset.
  always @(posedge bbc_phi0 or negedge resetb) begin
    if (!resetb) tb_ph1m <= 1'b0;
    else tb_ph1m <= ~tb_ph1m;
  end

  task automatic do_reset();
    resetb = 1'b0;
    cif.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge bbc_phi0);
    #40;
    resetb = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- driver ----------------
  task automatic run_access(input logic rnw, input logic [7:0] data,
                            input logic fe4x, input logic rom, input logic shadow,
                            output int lat_cyc, output int acks, output logic rnw_bad,
                            output logic start_ph1m, output logic [3:0] rom_ack,
                            output logic shadow_ack, output logic timed_out);
    int n;
    logic prev_lat;
    logic done;
    lat_cyc = 0; acks = 0; rnw_bad = 1'b0; start_ph1m = 1'b0;
    rom_ack = 4'h0; shadow_ack = 1'b0; prev_lat = 1'b0; done = 1'b0; n = 0;
    @(negedge clk);
    cif.cpu_rnw = rnw;
    cif.cpu_data = data;
    cif.dec_fe4x = fe4x;
    cif.dec_rom_reg = rom;
    cif.dec_shadow_reg = shadow;
    cif.cpu_req = 1'b1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        cif.dec_fe4x = ~fe4x;
        cif.dec_rom_reg = ~rom;
        cif.dec_shadow_reg = ~shadow;
      end
      if (lat_en) begin
        lat_cyc++;
        if (!prev_lat) start_ph1m = tb_ph1m;
        if (bbc_rnw !== rnw) rnw_bad = 1'b1;
      end
      prev_lat = lat_en;
      if (cif.cpu_ack) begin
        acks++;
        rom_ack = rom_bank;
        shadow_ack = shadow_en;
        if (bbc_rnw !== rnw) rnw_bad = 1'b1;
        cif.cpu_req = 1'b0;
        cif.dec_fe4x = 1'b0;
        cif.dec_rom_reg = 1'b0;
        cif.dec_shadow_reg = 1'b0;
        done = 1'b1;
      end
    end
    timed_out = !done;
    cif.cpu_req = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (cif.cpu_ack) acks++;
      if (lat_en) lat_cyc++;
      if (bbc_rnw !== 1'b1) rnw_bad = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (lat_en !== 1'b0) begin failures++; $display("FAIL reset_lat_en got=%b exp=0", lat_en); end
    checks++; if (bbc_rnw !== 1'b1) begin failures++; $display("FAIL reset_bbc_rnw got=%b exp=1", bbc_rnw); end
    checks++; if (cif.cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", cif.cpu_ack); end
    checks++; if (cif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", cif.busy); end
    checks++; if (rom_bank !== 4'h0) begin failures++; $display("FAIL reset_rom_bank got=%h exp=0", rom_bank); end
    checks++; if (shadow_en !== 1'b0) begin failures++; $display("FAIL reset_shadow got=%b exp=0", shadow_en); end
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_read_2mhz();
    int lat, acks; logic rb, ph, sh, to; logic [3:0] rk;
    run_access(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, lat, acks, rb, ph, rk, sh, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL read_timeout got=%b exp=0", to); end
    checks++; if (lat != 16) begin failures++; $display("FAIL read_lat_cycles got=%0d exp=16", lat); end
    checks++; if (acks != 1) begin failures++; $display("FAIL read_acks got=%0d exp=1", acks); end
    checks++; if (rb !== 1'b0) begin failures++; $display("FAIL read_bbc_rnw got_bad=%b exp=0", rb); end
    checks++; if (cif.busy !== 1'b0) begin failures++; $display("FAIL read_busy_after got=%b exp=0", cif.busy); end
  endtask

  task automatic test_rom_write();
    int lat, acks; logic rb, ph, sh, to; logic [3:0] rk;
    run_access(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, lat, acks, rb, ph, rk, sh, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL romwr_timeout got=%b exp=0", to); end
    checks++; if (rk !== 4'h5) begin failures++; $display("FAIL romwr_at_ack got=%h exp=5", rk); end
    checks++; if (lat != 16) begin failures++; $display("FAIL romwr_lat_cycles got=%0d exp=16", lat); end
    checks++; if (rb !== 1'b0) begin failures++; $display("FAIL romwr_bbc_rnw got_bad=%b exp=0", rb); end
    checks++; if (shadow_en !== 1'b0) begin failures++; $display("FAIL romwr_shadow got=%b exp=0", shadow_en); end
    run_access(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, lat, acks, rb, ph, rk, sh, to);
    checks++; if (rk !== 4'h5) begin failures++; $display("FAIL romrd_at_ack got=%h exp=5", rk); end
    checks++; if (rom_bank !== 4'h5) begin failures++; $display("FAIL romrd_after got=%h exp=5", rom_bank); end
    checks++; if (acks != 1) begin failures++; $display("FAIL romrd_acks got=%0d exp=1", acks); end
  endtask

  task automatic test_shadow_write();
    int lat, acks; logic rb, ph, sh, to; logic [3:0] rk;
    run_access(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, lat, acks, rb, ph, rk, sh, to);
    checks++; if (sh !== 1'b1) begin failures++; $display("FAIL shadow_set got=%b exp=1", sh); end
    checks++; if (rom_bank !== 4'h5) begin failures++; $display("FAIL shadow_set_rom got=%h exp=5", rom_bank); end
    run_access(1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, lat, acks, rb, ph, rk, sh, to);
    checks++; if (sh !== 1'b0) begin failures++; $display("FAIL shadow_clr got=%b exp=0", sh); end
    checks++; if (rom_bank !== 4'h5) begin failures++; $display("FAIL shadow_clr_rom got=%h exp=5", rom_bank); end
    checks++; if (acks != 1) begin failures++; $display("FAIL shadow_clr_acks got=%0d exp=1", acks); end
  endtask

  task automatic test_stretch();
    int lat, acks, n; logic rb, ph, sh, to; logic [3:0] rk;
    for (int phase = 0; phase < 2; phase++) begin
      n = 0;
      while (tb_ph1m !== phase[0] && n < 100) begin
        @(negedge clk);
        n++;
      end
      run_access(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, lat, acks, rb, ph, rk, sh, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL fe4x_timeout phase=%0d got=%b exp=0", phase, to); end
      checks++; if (lat != EXP_FE4X_LAT) begin failures++; $display("FAIL fe4x_lat_cycles phase=%0d got=%0d exp=%0d", phase, lat, EXP_FE4X_LAT); end
      checks++; if (acks != 1) begin failures++; $display("FAIL fe4x_acks phase=%0d got=%0d exp=1", phase, acks); end
`ifdef HOST_1MHZ_STRETCH_EN
      checks++; if (ph !== 1'b1) begin failures++; $display("FAIL fe4x_start_ph1m phase=%0d got=%b exp=1", phase, ph); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int n, acks, seg, gap; int seg_len[2]; logic prev_lat;
    acks = 0; seg = 0; gap = 0; n = 0; prev_lat = 1'b0;
    seg_len[0] = 0; seg_len[1] = 0;
    @(negedge clk);
    cif.cpu_rnw = 1'b1; cif.cpu_data = 8'h00;
    cif.dec_fe4x = 1'b0; cif.dec_rom_reg = 1'b0; cif.dec_shadow_reg = 1'b0;
    cif.cpu_req = 1'b1;
    while (acks < 2 && n < 600) begin
      @(negedge clk);
      n++;
      if (lat_en) begin
        if (!prev_lat && seg < 2 && seg_len[seg] != 0) seg++;
        if (seg < 2) seg_len[seg]++;
      end else if (seg_len[0] != 0 && seg == 0) begin
        gap++;
      end
      prev_lat = lat_en;
      if (cif.cpu_ack) begin
        acks++;
        if (acks == 2) cif.cpu_req = 1'b0;
      end
    end
    cif.cpu_req = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (cif.cpu_ack) acks++;
    end
    checks++; if (acks != 2) begin failures++; $display("FAIL b2b_acks got=%0d exp=2", acks); end
    checks++; if (seg_len[0] != 16) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=16", seg_len[0]); end
    checks++; if (seg_len[1] != 16) begin failures++; $display("FAIL b2b_second_lat got=%0d exp=16", seg_len[1]); end
    checks++; if (gap != 16) begin failures++; $display("FAIL b2b_gap got=%0d exp=16", gap); end
  endtask

  task automatic test_reset_mid();
    int n, acks;
    n = 0; acks = 0;
    @(negedge clk);
    cif.cpu_rnw = 1'b0; cif.cpu_data = 8'h0A;
    cif.dec_fe4x = 1'b0; cif.dec_rom_reg = 1'b1; cif.dec_shadow_reg = 1'b0;
    cif.cpu_req = 1'b1;
    while (state_dbg !== 3'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (state_dbg !== 3'd3) begin failures++; $display("FAIL rstmid_reach_data got=%0d exp=3", state_dbg); end
    resetb = 1'b0;
    #1;
    checks++; if (lat_en !== 1'b0) begin failures++; $display("FAIL rstmid_lat_en got=%b exp=0", lat_en); end
    checks++; if (cif.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", cif.busy); end
    checks++; if (rom_bank !== 4'h0) begin failures++; $display("FAIL rstmid_rom_bank got=%h exp=0", rom_bank); end
    checks++; if (bbc_rnw !== 1'b1) begin failures++; $display("FAIL rstmid_bbc_rnw got=%b exp=1", bbc_rnw); end
    repeat (5) begin
      @(negedge clk);
      if (cif.cpu_ack) acks++;
    end
    cif.cpu_req = 1'b0;
    cif.dec_rom_reg = 1'b0;
    do_reset();
    repeat (40) begin
      @(negedge clk);
      if (cif.cpu_ack) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
    checks++; if (rom_bank !== 4'h0) begin failures++; $display("FAIL rstmid_rom_after got=%h exp=0", rom_bank); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    resetb = 1'b0;
    cif.cpu_req = 1'b0;
    cif.cpu_rnw = 1'b1;
    cif.cpu_data = 8'h00;
    cif.dec_fe4x = 1'b0;
    cif.dec_rom_reg = 1'b0;
    cif.dec_shadow_reg = 1'b0;
    test_reset();
    test_read_2mhz();
    test_rom_write();
    test_shadow_write();
    test_stretch();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
